// File: rtl/puf_challenge_ctrl.sv
// Arbiter-PUF challenge sequencer: N_EVAL x (SETUP, LAUNCH, SAMPLE), majority vote, N_EVAL*(2*SETTLE_CYCLES+3) cycles per challenge.
// chal_ready only in IDLE (no queuing); the result is held in DONE with resp_valid until resp_ready.
module puf_challenge_ctrl #(
  parameter int N_STAGES      = 64,
  parameter int SETTLE_CYCLES = 8,
  parameter int N_EVAL        = 15,
  parameter int CNT_W         = $clog2(N_EVAL + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                chal_valid,
  output logic                chal_ready,
  input  logic [N_STAGES-1:0] chal_data,
  output logic [N_STAGES-1:0] puf_chal,
  output logic                puf_launch,
  input  logic                puf_resp,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_bit,
  output logic [CNT_W-1:0]    resp_ones,
  output logic                busy
);

  localparam int PH_W = $clog2(SETTLE_CYCLES + 2);
  localparam logic [PH_W-1:0]  SETUP_LAST  = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  LAUNCH_LAST = PH_W'(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] EVAL_LAST   = CNT_W'(N_EVAL);
  localparam logic [CNT_W-1:0] HALF        = CNT_W'(N_EVAL / 2);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LAUNCH,
    SAMPLE,
    DONE
  } state_e;

  state_e              state_q;
  logic [PH_W-1:0]     phase_q;
  logic [CNT_W-1:0]    eval_q;
  logic [CNT_W-1:0]    ones_q;
  logic [N_STAGES-1:0] puf_chal_q;
  logic                puf_launch_q;
  logic                resp_valid_q;
  logic                resp_bit_q;
  logic [CNT_W-1:0]    resp_ones_q;
  logic                resp_meta_q;
  logic                resp_s_q;

  logic [CNT_W-1:0]    eval_d;
  logic [CNT_W-1:0]    ones_d;

  // The arbiter output is asynchronous to clk; only resp_s_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_meta_q <= 1'b0;
      resp_s_q    <= 1'b0;
    end else begin
      resp_meta_q <= puf_resp;
      resp_s_q    <= resp_meta_q;
    end
  end

  assign eval_d = eval_q + CNT_W'(1);
  assign ones_d = ones_q + CNT_W'(resp_s_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      eval_q       <= '0;
      ones_q       <= '0;
      puf_chal_q   <= '0;
      puf_launch_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_bit_q   <= 1'b0;
      resp_ones_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (chal_valid) begin
            puf_chal_q <= chal_data;
            eval_q     <= '0;
            ones_q     <= '0;
            phase_q    <= '0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (phase_q == SETUP_LAST) begin
            phase_q      <= '0;
            puf_launch_q <= 1'b1;
            state_q      <= LAUNCH;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        LAUNCH: begin
          // Two extra cycles cover the synchronizer after the chain settles.
          if (phase_q == LAUNCH_LAST) begin
            phase_q <= '0;
            state_q <= SAMPLE;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        SAMPLE: begin
          ones_q       <= ones_d;
          eval_q       <= eval_d;
          puf_launch_q <= 1'b0;
          if (eval_d == EVAL_LAST) begin
            resp_valid_q <= 1'b1;
            resp_ones_q  <= ones_d;
            resp_bit_q   <= (ones_d > HALF);
            state_q      <= DONE;
          end else begin
            state_q <= SETUP;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          puf_launch_q <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign chal_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign puf_chal   = puf_chal_q;
  assign puf_launch = puf_launch_q;
  assign resp_valid = resp_valid_q;
  assign resp_bit   = resp_bit_q;
  assign resp_ones  = resp_ones_q;

endmodule
